// File: rtl/mem_stage_pkg.sv
// Shared widths, load codes and bus layouts for the memory stage.
// Bus structs match the execute->memory and memory->write-back packing.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 71;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef struct packed {
        logic        res_from_mem;
        logic [2:0]  load_op;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/halfword at off and extends it.
// Ports: mem_data (32), off (2), load_op (3) -> aligned (32).
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  off,
    input  logic [2:0]  load_op,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_data[{off, 3'b000} +: 8];
    // off[0] is ignored for halfwords; no misalignment trap here
    assign half_sel = off[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        aligned = mem_data;
        case (load_op)
            LD_B:    aligned = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   aligned = {24'd0, byte_sel};
            LD_H:    aligned = {{16{half_sel[15]}}, half_sel};
            LD_HU:   aligned = {16'd0, half_sel};
            default: aligned = mem_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: holds one instruction, waits for the data SRAM
// response, aligns loads and hands the result bus to write-back.
// Ports: clk/resetn; es_to_ms_valid/bus in, ms_allowin out;
// data_sram_data_ok/rdata in; ws_allowin in, ms_to_ws_valid/bus out;
// ms_to_ds_result, MS_dest, ms_load_pending out to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [31:0]                ms_to_ds_result,
    output logic [4:0]                 MS_dest,
    output logic                       ms_load_pending
);

    logic        ms_valid;
    es_to_ms_t   es_to_ms_bus_r;
    logic        resp_buf_valid;
    logic [31:0] resp_buf;

    logic        needs_resp;
    logic        ms_ready_go;
    logic        resp_capture;
    logic [31:0] mem_data;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;

    assign needs_resp  = es_to_ms_bus_r.res_from_mem
                       | es_to_ms_bus_r.mem_we;
    assign ms_ready_go = !needs_resp | resp_buf_valid
                       | data_sram_data_ok;
    assign ms_allowin  = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    // Response arrives while write-back is blocked: keep it, since
    // the SRAM will not repeat it.
    assign resp_capture = ms_valid & needs_resp & !resp_buf_valid
                        & data_sram_data_ok & !ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            es_to_ms_bus_r <= '0;
            resp_buf_valid <= 1'b0;
            resp_buf       <= 32'd0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid) begin
                    es_to_ms_bus_r <= es_to_ms_bus;
                    resp_buf_valid <= 1'b0;
                end
            end
            if (resp_capture) begin
                resp_buf       <= data_sram_rdata;
                resp_buf_valid <= 1'b1;
            end
        end
    end

    assign mem_data = resp_buf_valid ? resp_buf : data_sram_rdata;

    load_align u_load_align (
        .mem_data (mem_data),
        .off      (es_to_ms_bus_r.alu_result[1:0]),
        .load_op  (es_to_ms_bus_r.load_op),
        .aligned  (load_data)
    );

    assign final_result = es_to_ms_bus_r.res_from_mem
                        ? load_data
                        : es_to_ms_bus_r.alu_result;

    assign ws_bus.mem_we       = es_to_ms_bus_r.mem_we;
    assign ws_bus.gr_we        = es_to_ms_bus_r.gr_we;
    assign ws_bus.dest         = es_to_ms_bus_r.dest;
    assign ws_bus.final_result = final_result;
    assign ws_bus.pc           = es_to_ms_bus_r.pc;
    assign ms_to_ws_bus        = ws_bus;

    assign ms_to_ds_result = final_result;
    assign MS_dest         = ms_valid ? es_to_ms_bus_r.dest : 5'd0;
    assign ms_load_pending = ms_valid & es_to_ms_bus_r.res_from_mem
                           & !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, store,
// response buffering, back-to-back flow and reset mid-load.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [70:0] ms_to_ws_bus;
    logic [31:0] ms_to_ds_result;
    logic [4:0]  MS_dest;
    logic        ms_load_pending;

    int n_pass;
    int n_total;
    logic stray_ok;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_result   (ms_to_ds_result),
        .MS_dest           (MS_dest),
        .ms_load_pending   (ms_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [70:0] got,
                       input logic [70:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [74:0] mk(
        input logic        rfm,
        input logic [2:0]  lop,
        input logic        mwe,
        input logic        grwe,
        input logic [4:0]  dest,
        input logic [31:0] alu,
        input logic [31:0] pc);
        return {rfm, lop, mwe, grwe, dest, alu, pc};
    endfunction

    task automatic edge_step;
        @(posedge clk);
        #1;
    endtask

    // Protocol-correct data_ok always makes the stage ready.
    always @(negedge clk)
        if (resetn && data_sram_data_ok && !stray_ok)
            assert (ms_to_ws_valid)
            else $error("unexpected data_ok with stage not waiting");

    logic [2:0]  t_op  [8] = '{3'd1, 3'd2, 3'd3, 3'd3,
                               3'd7, 3'd2, 3'd4, 3'd0};
    logic [31:0] t_alu [8] = '{32'h10, 32'h11, 32'h13, 32'h14,
                               32'h15, 32'h16, 32'h18, 32'h1B};
    logic [31:0] t_rd  [8] = '{32'h1234_5687, 32'h1234_F678,
                               32'h9ABC_1234, 32'h0000_7FFF,
                               32'h55AA_55AA, 32'h00AB_0000,
                               32'hFFFF_8000, 32'h0BAD_CAFE};
    logic [31:0] t_exp [8] = '{32'hFFFF_FF87, 32'h0000_00F6,
                               32'hFFFF_9ABC, 32'h0000_7FFF,
                               32'h55AA_55AA, 32'h0000_00AB,
                               32'h0000_8000, 32'h0BAD_CAFE};

    initial begin
        n_pass = 0;
        n_total = 0;
        stray_ok = 1'b0;
        resetn = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        ws_allowin = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_allowin", 71'(ms_allowin), 71'd1);
        chk("rst_valid", 71'(ms_to_ws_valid), 71'd0);
        chk("rst_dest", 71'(MS_dest), 71'd0);
        chk("rst_pend", 71'(ms_load_pending), 71'd0);
        chk("rst_bus", ms_to_ws_bus, 71'd0);
        edge_step();
        resetn = 1'b1;
        edge_step();

        // ALU op
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(0, 3'd0, 0, 1, 5'd5,
                          32'h1234_5678, 32'h100);
        edge_step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("alu_valid", 71'(ms_to_ws_valid), 71'd1);
        chk("alu_res", 71'(ms_to_ws_bus[63:32]), 71'h1234_5678);
        chk("alu_fwd", 71'(ms_to_ds_result), 71'h1234_5678);
        chk("alu_dest", 71'(MS_dest), 71'd5);
        chk("alu_pc", 71'(ms_to_ws_bus[31:0]), 71'h100);
        chk("alu_grwe", 71'(ms_to_ws_bus[69]), 71'd1);
        edge_step();
        @(negedge clk);
        chk("alu_gone", 71'(ms_to_ws_valid), 71'd0);
        chk("alu_gone_dest", 71'(MS_dest), 71'd0);

        // lb off=3, response two cycles after entry
        edge_step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1, 3'd1, 0, 1, 5'd7, 32'h1003, 32'h104);
        edge_step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("lb_pend1", 71'(ms_load_pending), 71'd1);
        chk("lb_wait1", 71'(ms_to_ws_valid), 71'd0);
        chk("lb_allow1", 71'(ms_allowin), 71'd0);
        chk("lb_dest", 71'(MS_dest), 71'd7);
        edge_step();
        @(negedge clk);
        chk("lb_pend2", 71'(ms_load_pending), 71'd1);
        edge_step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("lb_valid", 71'(ms_to_ws_valid), 71'd1);
        chk("lb_pend0", 71'(ms_load_pending), 71'd0);
        chk("lb_res", 71'(ms_to_ws_bus[63:32]), 71'hFFFF_FF80);
        edge_step();
        data_sram_data_ok = 1'b0;

        // lhu off=2, response in first cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1, 3'd4, 0, 1, 5'd8, 32'h2002, 32'h108);
        edge_step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        @(negedge clk);
        chk("lhu_valid", 71'(ms_to_ws_valid), 71'd1);
        chk("lhu_pend", 71'(ms_load_pending), 71'd0);
        chk("lhu_res", 71'(ms_to_ws_bus[63:32]), 71'h0000_BEEF);
        edge_step();
        data_sram_data_ok = 1'b0;

        // lw with write-back blocked for 3 cycles
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1, 3'd0, 0, 1, 5'd9, 32'h3000, 32'h10C);
        edge_step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        ws_allowin = 1'b0;
        @(negedge clk);
        chk("lw_allow0", 71'(ms_allowin), 71'd0);
        chk("lw_res0", 71'(ms_to_ws_bus[63:32]), 71'hCAFE_F00D);
        for (int i = 1; i < 3; i++) begin
            edge_step();
            data_sram_data_ok = 1'b0;
            data_sram_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("lw_hold_valid", 71'(ms_to_ws_valid), 71'd1);
            chk("lw_hold_allow", 71'(ms_allowin), 71'd0);
            chk("lw_hold_res", 71'(ms_to_ws_bus[63:32]),
                71'hCAFE_F00D);
        end
        edge_step();
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("lw_rel_allow", 71'(ms_allowin), 71'd1);
        chk("lw_rel_res", 71'(ms_to_ws_bus[63:32]), 71'hCAFE_F00D);
        edge_step();
        @(negedge clk);
        chk("lw_gone", 71'(ms_to_ws_valid), 71'd0);
        edge_step();

        // load alignment table, response in first cycle
        for (int i = 0; i < 8; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk(1, t_op[i], 0, 1, 5'd10,
                              t_alu[i], 32'h200 + 32'(i));
            edge_step();
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = t_rd[i];
            @(negedge clk);
            chk($sformatf("ld_tab%0d", i),
                71'(ms_to_ws_bus[63:32]), 71'(t_exp[i]));
            edge_step();
            data_sram_data_ok = 1'b0;
        end

        // store waits one cycle for its response
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(0, 3'd0, 1, 0, 5'd0, 32'h5554, 32'h300);
        edge_step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("st_wait", 71'(ms_to_ws_valid), 71'd0);
        chk("st_pend", 71'(ms_load_pending), 71'd0);
        chk("st_allow", 71'(ms_allowin), 71'd0);
        edge_step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("st_valid", 71'(ms_to_ws_valid), 71'd1);
        chk("st_res", 71'(ms_to_ws_bus[63:32]), 71'h5554);
        chk("st_we", 71'(ms_to_ws_bus[70:69]), 71'b10);
        edge_step();
        data_sram_data_ok = 1'b0;

        // four back-to-back ALU ops
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(0, 3'd0, 0, 1, 5'd1, 32'h40, 32'h400);
        for (int i = 0; i < 4; i++) begin
            edge_step();
            if (i < 3)
                es_to_ms_bus = mk(0, 3'd0, 0, 1, 5'(i + 2),
                                  32'h40 + 32'(i + 1),
                                  32'h400 + 32'((i + 1) * 4));
            else
                es_to_ms_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", i),
                71'(ms_to_ws_valid), 71'd1);
            chk($sformatf("b2b_pc%0d", i),
                71'(ms_to_ws_bus[31:0]), 71'(32'h400 + i * 4));
            chk($sformatf("b2b_allow%0d", i),
                71'(ms_allowin), 71'd1);
        end
        edge_step();
        @(negedge clk);
        chk("b2b_end", 71'(ms_to_ws_valid), 71'd0);

        // reset during an outstanding load, then a stray data_ok
        edge_step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1, 3'd0, 0, 1, 5'd3, 32'h600, 32'h500);
        edge_step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("rl_pend", 71'(ms_load_pending), 71'd1);
        chk("rl_dest", 71'(MS_dest), 71'd3);
        edge_step();
        resetn = 1'b0;
        @(negedge clk);
        chk("rl_rst_valid", 71'(ms_to_ws_valid), 71'd0);
        chk("rl_rst_dest", 71'(MS_dest), 71'd0);
        edge_step();
        resetn = 1'b1;
        stray_ok = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("rl_stray_valid", 71'(ms_to_ws_valid), 71'd0);
        chk("rl_stray_dest", 71'(MS_dest), 71'd0);
        chk("rl_stray_allow", 71'(ms_allowin), 71'd1);
        chk("rl_stray_pend", 71'(ms_load_pending), 71'd0);
        edge_step();
        data_sram_data_ok = 1'b0;
        stray_ok = 1'b0;
        @(negedge clk);
        chk("rl_after_valid", 71'(ms_to_ws_valid), 71'd0);
        chk("rl_after_bus", ms_to_ws_bus, 71'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and the write-back stage. It holds one instruction per cycle, waits for the data-SRAM response on loads and stores, and byte/halfword-aligns and extends load data. It forms the 71-bit result bus and valid/allowin handshake consumed by write-back. It also exports forwarding and load-pending information to decode.

## Interface
- No parameters. Widths come from the shared header: `ES_TO_MS_BUS_WD`=75, `MS_TO_WS_BUS_WD`=71.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `es_to_ms_valid`  in  1  execute stage presents an instruction.
- `es_to_ms_bus`  in  75  fields:
  - {res_from_mem[74], load_op[73:71], mem_we[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- `ms_allowin`  out  1  stage can accept an instruction this cycle.
- `data_sram_data_ok`  in  1  one-cycle response pulse for the outstanding load/store.
- `data_sram_rdata`  in  32  read data, valid only with data_ok.
- `ws_allowin`  in  1  write-back can accept.
- `ms_to_ws_valid`  out  1  result bus valid.
- `ms_to_ws_bus`  out  71  {mem_we[70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- `ms_to_ds_result`  out  32  final_result for forwarding.
- `MS_dest`  out  5  dest gated by ms_valid (0 when empty).
- `ms_load_pending`  out  1  ms_valid & res_from_mem & !ms_ready_go; decode must stall a consumer of MS_dest.

## Operation
- Registers:
  - `ms_valid`.
  - `es_to_ms_bus_r` (75 bits).
  - `resp_buf_valid`.
  - `resp_buf` (32 bits).
- needs_resp = res_from_mem | mem_we.
- ms_ready_go = !needs_resp | resp_buf_valid | data_sram_data_ok.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- On ms_allowin:
  - ms_valid <= es_to_ms_valid.
  - If es_to_ms_valid also: latch bus, clear resp_buf_valid.
- Response capture: when ms_valid & needs_resp & !resp_buf_valid & data_ok & !ws_allowin:
  - resp_buf <= rdata; resp_buf_valid <= 1.
  - The response is held until write-back accepts.
- data_ok while !ms_valid, or while !needs_resp, or while resp_buf_valid = protocol error. It is ignored and must not change state. The bench asserts this never occurs.
- mem_data = resp_buf_valid ? resp_buf : data_sram_rdata.
- Load alignment, off = alu_result[1:0]:
  - load_op 000 lw: mem_data.
  - 001 lb: sign-extend byte[off].
  - 010 lbu: zero-extend byte[off].
  - 011 lh: sign-extend half[off[1]].
  - 100 lhu: zero-extend half[off[1]].
  - Other codes: treated as lw.
  - off[0] is ignored for halfwords; there is no address-error exception in this stage.
- final_result = res_from_mem ? aligned load : alu_result.
- Stores pass alu_result unchanged; gr_we is 0 from execute.

## Timing
- Reset (async assert, sync release):
  - ms_valid=0, resp_buf_valid=0, bus register and resp_buf=0.
  - Hence ms_allowin=1, ms_to_ws_valid=0, MS_dest=0, ms_load_pending=0, ms_to_ws_bus=0.
- Non-memory instruction: accepted at edge N, ms_to_ws_valid in cycle N, handed to write-back at edge N+1 if ws_allowin.
- Load/store: ms_to_ws_valid rises in the first cycle data_ok=1. That can be the first cycle in MS, since the request was handshaken in execute.
- Back-to-back: a new instruction enters on the same edge the old one leaves. Throughput is 1/cycle with no memory stall.
- data_ok and !ws_allowin in the same cycle: buffer the response. Output remains valid from the buffer in later cycles; no second data_ok is expected.
- Reset asserted mid-load: the instruction is discarded; a late data_ok after reset release is ignored (ms_valid=0).

## Structure
- Shared header `mycpu.h`:
  - Add `ES_TO_MS_BUS_WD` and the load_op codes (`LD_W`, `LD_B`, `LD_BU`, `LD_H`, `LD_HU`).
  - `MS_TO_WS_BUS_WD` already lives there.
- One combinational sub-module `load_align` (mem_data, off, load_op -> aligned). The handshake, buffer and bus register live in mem_stage.

## Test plan
- ALU op, alu_result=0x1234_5678, dest=5, ws_allowin=1 -> next cycle ms_to_ws_bus.final_result=0x1234_5678, MS_dest=5, valid for 1 cycle.
- lb, off=3, rdata=0x80FF_0000, data_ok 2 cycles after entry -> ms_load_pending=1 for 2 cycles, then final_result=0xFFFF_FF80.
- lhu, off=2, rdata=0xBEEF_1234, data_ok in the first cycle -> final_result=0x0000_BEEF, no stall.
- lw, data_ok with ws_allowin=0 for 3 cycles, rdata changes to junk afterward -> output holds the captured word, ms_allowin=0 until accepted.
- Back-to-back 4 ALU ops with es_to_ms_valid=1 -> 4 consecutive ms_to_ws_valid cycles, pcs in order.
- resetn low mid-load, then a stray data_ok -> ms_to_ws_valid stays 0, MS_dest=0, ms_allowin=1.
